// File: rtl/password_entry_sequencer.sv
// rtl/password_entry_sequencer.sv - multi-digit code entry, ROM fetch, compare and per-user lockout
module password_entry_sequencer #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int USER_W         = 2,
    parameter int MAX_FAILS      = 3,
    parameter int RESULT_CYCLES  = 4,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIGIT_W-1:0]        userInp,
    input  logic                      userBtn,
    input  logic [USER_W-1:0]         userId,
    output logic                      rom_req,
    output logic [USER_W-1:0]         rom_addr,
    input  logic                      rom_ack,
    input  logic [DIGITS*DIGIT_W-1:0] rom_data,
    output logic                      accessGranted,
    output logic                      accessDenied,
    output logic                      locked,
    output logic                      busy
);
    localparam int CODE_W  = DIGITS * DIGIT_W;
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int NUSERS  = 1 << USER_W;
    localparam int TMAX_A  = (RESULT_CYCLES > LOCKOUT_CYCLES) ? RESULT_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX    = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, COLLECT, FETCH, COMPARE, GRANT, DENY, LOCKOUT
    } state_t;

    state_t              state, nextState;
    logic                btnPrev;
    logic [CNT_W-1:0]    cnt;
    logic [TIMER_W-1:0]  timer;
    logic [CODE_W-1:0]   entered, stored;
    logic [USER_W-1:0]   idReg;
    logic [FAIL_W-1:0]   failCnt [NUSERS];

    logic                press;
    logic                codeMatch;
    logic [FAIL_W-1:0]   failNext;
    logic [CODE_W-1:0]   shifted;

    assign press     = userBtn & ~btnPrev;
    assign codeMatch = (entered == stored);
    assign failNext  = failCnt[idReg] + FAIL_W'(1);
    // Truncating the concatenation drops the oldest digit and also covers DIGITS == 1.
    assign shifted   = CODE_W'({entered, userInp});
    assign rom_addr  = idReg;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        rom_req       = 1'b0;
        accessGranted = 1'b0;
        accessDenied  = 1'b0;
        locked        = 1'b0;
        case (state)
            IDLE: begin
                if (press) nextState = (DIGITS == 1) ? FETCH : COLLECT;
            end
            COLLECT: begin
                if (press) begin
                    if (cnt == CNT_W'(DIGITS - 1)) nextState = FETCH;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    nextState = IDLE;
                end
            end
            FETCH: begin
                rom_req = 1'b1;
                if (rom_ack) nextState = COMPARE;
            end
            COMPARE: begin
                if (codeMatch)                           nextState = GRANT;
                else if (failNext == FAIL_W'(MAX_FAILS)) nextState = LOCKOUT;
                else                                     nextState = DENY;
            end
            GRANT: begin
                accessGranted = 1'b1;
                if (timer == TIMER_W'(RESULT_CYCLES - 1)) nextState = IDLE;
            end
            DENY: begin
                accessDenied = 1'b1;
                if (timer == TIMER_W'(RESULT_CYCLES - 1)) nextState = IDLE;
            end
            LOCKOUT: begin
                locked       = 1'b1;
                accessDenied = 1'b1;
                if (timer == TIMER_W'(LOCKOUT_CYCLES - 1)) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // The timer restarts on every state change and on each digit press while collecting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btnPrev <= 1'b0;
            cnt     <= '0;
            timer   <= '0;
            entered <= '0;
            stored  <= '0;
            idReg   <= '0;
            for (int u = 0; u < NUSERS; u++) failCnt[u] <= '0;
        end else begin
            btnPrev <= userBtn;
            if ((nextState != state) || (press && state == COLLECT)) timer <= '0;
            else                                                      timer <= timer + TIMER_W'(1);
            case (state)
                IDLE: begin
                    if (press) begin
                        idReg   <= userId;
                        entered <= shifted;
                        cnt     <= CNT_W'(1);
                    end
                end
                COLLECT: begin
                    if (press) begin
                        entered <= shifted;
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
                FETCH: begin
                    if (rom_ack) stored <= rom_data;
                end
                COMPARE: begin
                    failCnt[idReg] <= codeMatch ? '0 : failNext;
                end
                LOCKOUT: begin
                    if (nextState == IDLE) failCnt[idReg] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_password_entry_sequencer.sv
// tb/tb_password_entry_sequencer.sv - scoreboard bench with randomized code entry and a per-user fail model
module tb_password_entry_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  userInp = '0;
    logic        userBtn = 1'b0;
    logic [1:0]  userId = '0;
    logic        rom_req;
    logic [1:0]  rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = '0;
    logic        accessGranted, accessDenied, locked, busy;

    always #5 clk = ~clk;

    password_entry_sequencer dut (
        .clk(clk), .reset(reset), .userInp(userInp), .userBtn(userBtn), .userId(userId),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .accessGranted(accessGranted), .accessDenied(accessDenied), .locked(locked), .busy(busy)
    );

    int nVectors = 0;
    int nMiscompares = 0;
    int expKind[$];
    int expLen[$];
    logic [15:0] rom [4];
    int fails [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        userInp = d;
        userBtn = 1'b1;
        tick();
        userBtn = 1'b0;
    endtask

    // Result kinds: 0 granted, 1 denied, 2 locked out.
    task automatic expectResult(input int id, input logic [15:0] code);
        if (code == rom[id]) begin
            fails[id] = 0;
            expKind.push_back(0); expLen.push_back(4);
        end else begin
            fails[id]++;
            if (fails[id] == 3) begin
                fails[id] = 0;
                expKind.push_back(2); expLen.push_back(16);
            end else begin
                expKind.push_back(1); expLen.push_back(4);
            end
        end
    endtask

    task automatic enterCode(input int id, input logic [15:0] code, input int maxGap);
        logic [15:0] c;
        c = code;
        userId = 2'(id);
        for (int i = 0; i < 4; i++) begin
            press(c[15-4*i -: 4]);
            userId = 2'($urandom_range(0, 3));
            if (i < 3) repeat (1 + $urandom_range(0, maxGap)) tick();
        end
        check("rom_req_at_last_press", rom_req, 1);
    endtask

    task automatic serveRom(input int id, input int delay);
        int n;
        n = 0;
        while (!rom_req && n < 50) begin tick(); n++; end
        check("rom_req_seen", rom_req, 1);
        check("rom_addr", rom_addr, id);
        repeat (delay) tick();
        check("rom_req_hold", rom_req, 1);
        rom_data = rom[id];
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
        rom_data = 16'($urandom);
        check("rom_req_after_ack", rom_req, 0);
        check("compare_quiet", accessGranted | accessDenied, 0);
        tick();
        check("result_latency", accessGranted | accessDenied, 1);
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin tick(); n++; end
        check("return_to_idle", busy, 0);
    endtask

    task automatic transaction(input int id, input logic [15:0] code, input int maxGap,
                               input int delay, input bit poke);
        expectResult(id, code);
        enterCode(id, code, maxGap);
        serveRom(id, delay);
        if (poke) repeat (4) begin press(4'($urandom)); tick(); end
        waitIdle(40);
    endtask

    task automatic abortEntry(input int id, input logic [15:0] code, input int n);
        logic [15:0] c;
        logic sawReq;
        c = code;
        userId = 2'(id);
        for (int i = 0; i < n; i++) begin
            press(c[15-4*i -: 4]);
            if (i < n - 1) repeat (1 + $urandom_range(0, 3)) tick();
        end
        sawReq = 1'b0;
        repeat (31) begin tick(); sawReq |= rom_req; end
        check("timeout_not_yet", busy, 1);
        tick();
        sawReq |= rom_req;
        check("timeout_idle", busy, 0);
        check("timeout_no_req", sawReq, 0);
        check("timeout_no_result", accessGranted | accessDenied | locked, 0);
    endtask

    // Monitor: measures each contiguous result pulse and checks it against the scoreboard.
    int runKind = -1;
    int runLen = 0;
    always @(negedge clk) begin
        int curKind;
        if (!reset) begin
            runKind = -1;
            runLen = 0;
        end else begin
            check("granted_denied_exclusive", accessGranted & accessDenied, 0);
            if (accessGranted)     curKind = locked ? 3 : 0;
            else if (accessDenied) curKind = locked ? 2 : 1;
            else                   curKind = locked ? 3 : -1;
            if (curKind == runKind && curKind != -1) begin
                runLen++;
            end else begin
                if (runKind != -1) begin
                    if (expKind.size() == 0) begin
                        nVectors++;
                        nMiscompares++;
                        $display("FAIL unexpected_result: kind %0d len %0d, expected none", runKind, runLen);
                    end else begin
                        check("result_kind", runKind, expKind.pop_front());
                        check("result_len", runLen, expLen.pop_front());
                    end
                end
                runKind = curKind;
                runLen = (curKind == -1) ? 0 : 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] code;
        int id;
        rom[0] = 16'h5A3C; rom[1] = 16'h7123; rom[2] = 16'h9E01; rom[3] = 16'hB4F6;
        for (int u = 0; u < 4; u++) fails[u] = 0;

        repeat (2) tick();
        check("reset_rom_req", rom_req, 0);
        check("reset_outputs", {accessGranted, accessDenied, locked, busy}, 0);
        check("reset_rom_addr", rom_addr, 0);
        reset = 1'b1;
        tick();

        transaction(0, 16'h5A3C, 2, 2, 0);
        transaction(0, 16'h5A3D, 1, 0, 0);
        transaction(0, 16'h5A3C, 3, 1, 0);

        transaction(1, 16'h1111, 0, 1, 0);
        transaction(1, 16'h2222, 2, 3, 0);
        transaction(1, 16'h3333, 1, 0, 1);
        check("lockout_released", locked, 0);
        transaction(2, 16'h9E01, 1, 2, 0);

        abortEntry(0, 16'h5A00, 2);
        transaction(0, 16'h5A3C, 1, 1, 0);

        transaction(3, 16'h0000, 0, 0, 0);
        transaction(3, 16'h0001, 0, 0, 0);
        enterCode(3, 16'h0002, 1);
        reset = 1'b0;
        #1;
        check("reset_mid_fetch_req", rom_req, 0);
        check("reset_mid_fetch_outputs", {accessGranted, accessDenied, locked, busy}, 0);
        for (int u = 0; u < 4; u++) fails[u] = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        transaction(3, 16'h0003, 1, 1, 0);
        transaction(3, 16'hB4F6, 1, 1, 0);

        code = {4'h7, rom[1][11:0]};
        expectResult(1, code);
        userId = 2'd1;
        userInp = 4'h7;
        userBtn = 1'b1;
        repeat (10) tick();
        userBtn = 1'b0;
        check("held_button_collect", busy, 1);
        check("held_button_no_req", rom_req, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            press(code[15-4*i -: 4]);
        end
        serveRom(1, 1);
        waitIdle(40);

        for (int t = 0; t < 60; t++) begin
            id = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) code = rom[id];
            else                           code = rom[id] ^ 16'($urandom_range(1, 65535));
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 7) == 0)
                abortEntry(id, code, $urandom_range(1, 3));
            else
                transaction(id, code, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("pending_expectations", expKind.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
